// File: rtl/nihilist_decrypt.sv
// nihilist_decrypt
// Streaming decryptor for the keyed-Polybius Nihilist cipher. Each cipher
// byte is the sum of the plaintext letter code and the code of the current
// secret letter. The secret repeats across the message.
//
// Ports
//   i_w_clk, i_w_rst_n          clock, asynchronous active-low reset
//   i_w_start, i_w_secret       begin a message and latch the secret (IDLE only);
//                               character 0 is the MSB byte of i_w_secret
//   i_w_cipher_valid/i_w_cipher cipher byte input
//   o_r_cipher_ready            cipher handshake ready
//   o_r_text_valid/o_r_text     decoded ASCII output
//   i_w_text_ready              text handshake ready from the sink
//   o_r_done                    one-cycle pulse after the last text transfer
//   o_r_error                   sticky error flag, cleared by i_w_start
module nihilist_decrypt #(
    parameter int p_message_length = 9,
    parameter int p_secret_length  = 6
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_rst_n,
    input  logic                         i_w_start,
    input  logic [p_secret_length*8-1:0] i_w_secret,
    input  logic                         i_w_cipher_valid,
    input  logic [7:0]                   i_w_cipher,
    output logic                         o_r_cipher_ready,
    output logic                         o_r_text_valid,
    output logic [7:0]                   o_r_text,
    input  logic                         i_w_text_ready,
    output logic                         o_r_done,
    output logic                         o_r_error
);

    localparam int KW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
    localparam int CW = $clog2(p_message_length + 1);

    typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_t;

    state_t                       state_q, state_d;
    logic [p_secret_length*8-1:0] secret_q, secret_d;
    logic [KW-1:0]                key_idx_q, key_idx_d;
    logic [CW-1:0]                count_q, count_d;
    logic [7:0]                   text_q, text_d;
    logic                         text_valid_q, text_valid_d;
    logic                         cipher_ready_q, cipher_ready_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;

    // Keyed square code (10*row + col); J shares I's cell. Non-letters give 0.
    function automatic logic [5:0] letter_code(input logic [7:0] c);
        case (c)
            "D": letter_code = 6'd11;  "A": letter_code = 6'd12;
            "N": letter_code = 6'd13;  "I": letter_code = 6'd14;
            "J": letter_code = 6'd14;  "E": letter_code = 6'd15;
            "L": letter_code = 6'd21;  "B": letter_code = 6'd22;
            "C": letter_code = 6'd23;  "F": letter_code = 6'd24;
            "G": letter_code = 6'd25;  "H": letter_code = 6'd31;
            "K": letter_code = 6'd32;  "M": letter_code = 6'd33;
            "O": letter_code = 6'd34;  "P": letter_code = 6'd35;
            "Q": letter_code = 6'd41;  "R": letter_code = 6'd42;
            "S": letter_code = 6'd43;  "T": letter_code = 6'd44;
            "U": letter_code = 6'd45;  "V": letter_code = 6'd51;
            "W": letter_code = 6'd52;  "X": letter_code = 6'd53;
            "Y": letter_code = 6'd54;  "Z": letter_code = 6'd55;
            default: letter_code = 6'd0;
        endcase
    endfunction

    // Square cell to letter; {row,col} reads naturally as a two-digit octal.
    function automatic logic [7:0] cell_letter(input logic [2:0] row, input logic [2:0] col);
        case ({row, col})
            6'o11: cell_letter = "D";  6'o12: cell_letter = "A";  6'o13: cell_letter = "N";
            6'o14: cell_letter = "I";  6'o15: cell_letter = "E";  6'o21: cell_letter = "L";
            6'o22: cell_letter = "B";  6'o23: cell_letter = "C";  6'o24: cell_letter = "F";
            6'o25: cell_letter = "G";  6'o31: cell_letter = "H";  6'o32: cell_letter = "K";
            6'o33: cell_letter = "M";  6'o34: cell_letter = "O";  6'o35: cell_letter = "P";
            6'o41: cell_letter = "Q";  6'o42: cell_letter = "R";  6'o43: cell_letter = "S";
            6'o44: cell_letter = "T";  6'o45: cell_letter = "U";  6'o51: cell_letter = "V";
            6'o52: cell_letter = "W";  6'o53: cell_letter = "X";  6'o54: cell_letter = "Y";
            6'o55: cell_letter = "Z";
            default: cell_letter = 8'h3F;
        endcase
    endfunction

    // Decode datapath for the byte currently on i_w_cipher.
    logic [7:0]        key_char;
    logic              key_bad;
    logic signed [8:0] diff;
    logic signed [8:0] tens_base;
    logic signed [8:0] units;
    logic [2:0]        tens;
    logic              diff_ok;
    logic [7:0]        decoded;

    always_comb begin
        key_char = secret_q[8*(p_secret_length-1-int'(key_idx_q)) +: 8];
        key_bad  = (key_char < "A") || (key_char > "Z");
        // 9-bit signed so a cipher byte below the key code shows up negative.
        diff     = $signed({1'b0, i_w_cipher}) - $signed({3'b000, letter_code(key_char)});
        if (diff >= 9'sd50) begin
            tens = 3'd5; tens_base = 9'sd50;
        end else if (diff >= 9'sd40) begin
            tens = 3'd4; tens_base = 9'sd40;
        end else if (diff >= 9'sd30) begin
            tens = 3'd3; tens_base = 9'sd30;
        end else if (diff >= 9'sd20) begin
            tens = 3'd2; tens_base = 9'sd20;
        end else if (diff >= 9'sd10) begin
            tens = 3'd1; tens_base = 9'sd10;
        end else begin
            tens = 3'd0; tens_base = 9'sd0;
        end
        units   = diff - tens_base;
        diff_ok = (diff >= 9'sd11) && (diff <= 9'sd55) &&
                  (units >= 9'sd1) && (units <= 9'sd5);
        decoded = diff_ok ? cell_letter(tens, units[2:0]) : 8'h3F;
    end

    always_comb begin
        state_d        = state_q;
        secret_d       = secret_q;
        key_idx_d      = key_idx_q;
        count_d        = count_q;
        text_d         = text_q;
        text_valid_d   = text_valid_q;
        cipher_ready_d = cipher_ready_q;
        done_d         = 1'b0;
        error_d        = error_q;
        case (state_q)
            IDLE: begin
                if (i_w_start) begin
                    secret_d       = i_w_secret;
                    key_idx_d      = '0;
                    count_d        = '0;
                    error_d        = 1'b0;
                    cipher_ready_d = 1'b1;
                    state_d        = RECV;
                end
            end
            RECV: begin
                // cipher_ready_q is high throughout RECV, so valid alone means transfer.
                if (i_w_cipher_valid) begin
                    text_d         = decoded;
                    text_valid_d   = 1'b1;
                    cipher_ready_d = 1'b0;
                    if (!diff_ok || key_bad) error_d = 1'b1;
                    key_idx_d      = (int'(key_idx_q) == p_secret_length - 1) ? '0 : key_idx_q + KW'(1);
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (i_w_text_ready) begin
                    text_valid_d = 1'b0;
                    count_d      = count_q + CW'(1);
                    if (int'(count_q) + 1 == p_message_length) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cipher_ready_d = 1'b1;
                        state_d        = RECV;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q        <= IDLE;
            secret_q       <= '0;
            key_idx_q      <= '0;
            count_q        <= '0;
            text_q         <= 8'h00;
            text_valid_q   <= 1'b0;
            cipher_ready_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            secret_q       <= secret_d;
            key_idx_q      <= key_idx_d;
            count_q        <= count_d;
            text_q         <= text_d;
            text_valid_q   <= text_valid_d;
            cipher_ready_q <= cipher_ready_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign o_r_cipher_ready = cipher_ready_q;
    assign o_r_text_valid   = text_valid_q;
    assign o_r_text         = text_q;
    assign o_r_done         = done_q;
    assign o_r_error        = error_q;

endmodule

// File: doc/nihilist_decrypt.md
# nihilist_decrypt

- Streaming decryptor for the Nihilist-style cipher produced by the team's `encrypt` block.
- Each cipher byte is the binary value of the decimal sum of two keyed-Polybius codes: plaintext letter plus secret letter, with the secret repeating.
- The block takes cipher bytes one at a time over a valid/ready handshake, subtracts the secret letter's code, and maps the difference back to an uppercase ASCII letter.
- It emits the recovered text bytes in message order over a second valid/ready handshake.

## Interface
- p_message_length, 9, number of cipher bytes per message.
- p_secret_length, 6, number of ASCII characters in the secret.
- i_w_clk  in  1  clock; all state changes on rising edge.
- i_w_rst_n  in  1  reset, asynchronous, active-low.
- i_w_start  in  1  one-cycle pulse; latches i_w_secret and begins a message. Honoured only in IDLE.
- i_w_secret  in  p_secret_length*8  secret string; character 0 is the MSB byte.
- i_w_cipher_valid  in  1  cipher byte is available.
- i_w_cipher  in  8  cipher byte (expected range 22..110).
- o_r_cipher_ready  out  1  block accepts a cipher byte this cycle.
- o_r_text_valid  out  1  o_r_text holds a decoded character.
- o_r_text  out  8  decoded ASCII character.
- i_w_text_ready  in  1  sink accepts o_r_text.
- o_r_done  out  1  one-cycle pulse after the last character is accepted.
- o_r_error  out  1  sticky; set on any invalid secret character or undecodable cipher byte; cleared on i_w_start.

## Operation
- Keyed square, with code = 10*row + col:
  - row 1: D A N I E
  - row 2: L B C F G
  - row 3: H K M O P
  - row 4: Q R S T U
  - row 5: V W X Y Z
  - J encodes as I (14). Examples: D=11, T=44, Z=55.
- Secret character outside 'A'..'Z':
  - its code is 0.
  - o_r_error is set when that character is used.
- States: IDLE, RECV, SEND, DONE.
- IDLE:
  - On i_w_start: latch secret, key index = 0, message count = 0, clear o_r_error, go to RECV.
- RECV:
  - o_r_cipher_ready = 1.
  - On i_w_cipher_valid: compute d = i_w_cipher - code(secret[key index]).
    - If 11 <= d <= 55 with tens digit 1..5 and units digit 1..5, o_r_text = letter at that row/col.
    - Otherwise (including cipher < key code, i.e. negative d), o_r_text = '?' (0x3F) and o_r_error is set.
  - Then: o_r_text_valid = 1, key index advances, go to SEND.
- SEND:
  - o_r_text and o_r_text_valid are held stable until i_w_text_ready.
  - On i_w_text_ready: o_r_text_valid = 0, count increments.
  - If count reaches p_message_length, go to DONE; else go to RECV.
- DONE:
  - o_r_done = 1 for exactly one cycle, then go to IDLE.
- Key index wraps from p_secret_length-1 to 0. The secret repeats across the message.
- i_w_start outside IDLE is ignored; the latched secret is unaffected.
- Digit split of d uses comparison/subtraction against multiples of 10. Width of d is 9 bits signed, so d < 0 is detected.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - o_r_cipher_ready, o_r_text_valid, o_r_done, o_r_error = 0.
  - o_r_text = 8'h00; counters = 0.
- o_r_cipher_ready and o_r_text_valid are registered, never both high.
- Latency: a cipher byte accepted at edge k gives o_r_text_valid = 1 after edge k.
- Throughput: peak one character per 2 cycles, with text_ready held high.
- Valid/ready handshakes (cipher in, text out): transfer occurs on a rising edge with both signals high.
- Reset mid-message aborts immediately. No o_r_done is generated. Partial text is discarded.
- o_r_done rises the edge after the final text handshake.

## Test plan
- Stream 55,46,48,57,36,35,53,27,57 with secret "DANILA", text_ready=1 -> o_r_text "TOPSECRET" in order; o_r_done one pulse; o_r_error=0.
  - The 7th byte (53) decodes with key index wrapped to 0 ('D'), giving 'R'.
- Same stream with i_w_text_ready low for 3 cycles on character 2 -> o_r_text='O' held stable; o_r_cipher_ready=0 throughout; sequence unchanged.
- Cipher byte 10 with key 'D' (d=-1), and byte 77 with key 'D' (d=66) -> each outputs 0x3F; o_r_error=1 and stays 1 until the next i_w_start.
- Secret "DAN1LA" -> '1' has code 0; byte 4 with cipher 44 decodes to 'T'; o_r_error=1.
- Assert i_w_rst_n low after the 4th character -> all outputs 0 asynchronously; no o_r_done. A new i_w_start afterwards decodes a full message correctly.
- i_w_start pulsed during RECV with a different secret -> ignored; "TOPSECRET" still decoded with "DANILA".
